// File: rtl/dpram_tdp_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg : shared types and helpers for the dpram_tdp RAM.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  // Even parity: the returned bit makes the total count of ones even.
  // Zero-extension by the caller leaves the result unchanged.
  function automatic logic parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpram_clear_fsm.sv
// ---------------------------------------------------------------------------
// dpram_clear_fsm : post-reset sweep that zeroes every word once.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpram_clear_fsm
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // One extra counter bit lets DEPTH == 2**ADDR_W finish without wrapping.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  clr_state_t        state;
  logic [ADDR_W:0]   cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ONE;
          if (cnt == LAST) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          init_busy <= 1'b0;
        end
        default: begin
          state     <= CLEAR;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/dpram_tdp.sv
// ---------------------------------------------------------------------------
// dpram_tdp : single-clock true dual-port RAM, port A wins write-write.
// Optional DPRAM_TDP_PARITY_EN adds per-word even parity + error flags. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpram_tdp
  import dpram_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int RDW_MODE = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob,
  output logic              collision
`ifdef DPRAM_TDP_PARITY_EN
  ,
  output logic              par_err_a,
  output logic              par_err_b
`endif
);

`ifdef DPRAM_TDP_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W+1)'(DEPTH);
  localparam logic            WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              a_in, b_in, a_wr, b_wr;
  logic [MEM_W-1:0]  rd_a, rd_b, wd_a, wd_b;

  dpram_clear_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_fsm (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign a_in = ({1'b0, addra} < DEPTH_L);
  assign b_in = ({1'b0, addrb} < DEPTH_L);
  assign a_wr = ena && wea && a_in && !clr_we;
  // Port B's write is dropped whenever port A writes the same word.
  assign b_wr = enb && web && b_in && !clr_we && !(a_wr && (addra == addrb));

`ifdef DPRAM_TDP_PARITY_EN
  assign wd_a = {parity(64'(dia)), dia};
  assign wd_b = {parity(64'(dib)), dib};
`else
  assign wd_a = dia;
  assign wd_b = dib;
`endif

  assign rd_a = mem[addra];
  assign rd_b = mem[addrb];

  always_ff @(posedge clk1) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (a_wr) mem[addra] <= wd_a;
      if (b_wr) mem[addrb] <= wd_b;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n || clr_we) begin
      doa       <= '0;
      dob       <= '0;
      collision <= 1'b0;
`ifdef DPRAM_TDP_PARITY_EN
      par_err_a <= 1'b0;
      par_err_b <= 1'b0;
`endif
    end else begin
      collision <= ena && enb && (addra == addrb) && (wea || web);
      if (ena) begin
        if (!a_in)                    doa <= '0;
        else if (wea && WRITE_FIRST)  doa <= dia;
        else                          doa <= rd_a[DATA_W-1:0];
`ifdef DPRAM_TDP_PARITY_EN
        par_err_a <= a_in && !(wea && WRITE_FIRST) &&
                     (parity(64'(rd_a[DATA_W-1:0])) != rd_a[DATA_W]);
`endif
      end
      if (enb) begin
        if (!b_in)                    dob <= '0;
        else if (web && WRITE_FIRST)  dob <= dib;
        else                          dob <= rd_b[DATA_W-1:0];
`ifdef DPRAM_TDP_PARITY_EN
        par_err_b <= b_in && !(web && WRITE_FIRST) &&
                     (parity(64'(rd_b[DATA_W-1:0])) != rd_b[DATA_W]);
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpram_tdp.sv
// ---------------------------------------------------------------------------
// tb_dpram_tdp : checks a read-first 32-word RAM and a write-first 24-word RAM
// driven in parallel. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dpram_tdp;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       ena, wea, enb, web;
  logic [4:0] addra, addrb;
  logic [3:0] dia, dib;
  logic [3:0] doa0, dob0, doa1, dob1;
  logic       busy0, busy1, col0, col1;
`ifdef DPRAM_TDP_PARITY_EN
  logic       pea0, peb0, pea1, peb1;
`endif

  always #5 clk1 = ~clk1;

  dpram_tdp #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0)) u_main (
    .clk1(clk1), .rst_n(rst_n), .init_busy(busy0),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa0),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob0),
    .collision(col0)
`ifdef DPRAM_TDP_PARITY_EN
    , .par_err_a(pea0), .par_err_b(peb0)
`endif
  );

  dpram_tdp #(.DATA_W(4), .ADDR_W(5), .DEPTH(24), .RDW_MODE(1)) u_wf (
    .clk1(clk1), .rst_n(rst_n), .init_busy(busy1),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa1),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob1),
    .collision(col1)
`ifdef DPRAM_TDP_PARITY_EN
    , .par_err_a(pea1), .par_err_b(peb1)
`endif
  );

  typedef struct {
    logic       ena, wea;
    logic [4:0] addra;
    logic [3:0] dia;
    logic       enb, web;
    logic [4:0] addrb;
    logic [3:0] dib;
    logic [3:0] xa0, xb0, xa1, xb1;
    logic       xc;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: plain word arrays, reads see pre-edge contents.
  logic [3:0] m0 [32];
  logic [3:0] m1 [24];
  logic [3:0] qa0, qb0, qa1, qb1;
  logic       qc;

  function automatic vec_t mk(input int ea, input int wa, input int aa, input int da,
                              input int eb, input int wb, input int ab, input int db,
                              input int xa0, input int xb0, input int xa1, input int xb1,
                              input int xc);
    vec_t v;
    v.ena = ea[0];  v.wea = wa[0];  v.addra = aa[4:0];  v.dia = da[3:0];
    v.enb = eb[0];  v.web = wb[0];  v.addrb = ab[4:0];  v.dib = db[3:0];
    v.xa0 = xa0[3:0]; v.xb0 = xb0[3:0]; v.xa1 = xa1[3:0]; v.xb1 = xb1[3:0];
    v.xc  = xc[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m0[i] = 4'h0;
    for (int i = 0; i < 24; i++) m1[i] = 4'h0;
    qa0 = 4'h0; qb0 = 4'h0; qa1 = 4'h0; qb1 = 4'h0; qc = 1'b0;
  endtask

  task automatic model_step();
    if (ena) begin
      qa0 = m0[addra];
      qa1 = (addra >= 24) ? 4'h0 : (wea ? dia : m1[addra]);
    end
    if (enb) begin
      qb0 = m0[addrb];
      qb1 = (addrb >= 24) ? 4'h0 : (web ? dib : m1[addrb]);
    end
    qc = ena && enb && (addra == addrb) && (wea || web);
    // Apply B before A so that A's data is what remains on a shared word.
    if (enb && web) begin
      m0[addrb] = dib;
      if (addrb < 24) m1[addrb] = dib;
    end
    if (ena && wea) begin
      m0[addra] = dia;
      if (addra < 24) m1[addra] = dia;
    end
  endtask

  task automatic drive(input vec_t v);
    ena = v.ena; wea = v.wea; addra = v.addra; dia = v.dia;
    enb = v.enb; web = v.web; addrb = v.addrb; dib = v.dib;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; addra = 5'd0; dia = 4'h0;
    enb = 1'b0; web = 1'b0; addrb = 5'd0; dib = 4'h0;
  endtask

  task automatic drive_random();
    ena   = ($urandom_range(0, 3) != 0);
    enb   = ($urandom_range(0, 3) != 0);
    wea   = $urandom_range(0, 1) == 1;
    web   = $urandom_range(0, 1) == 1;
    addra = 5'($urandom_range(0, 31));
    addrb = ($urandom_range(0, 3) == 0) ? addra : 5'($urandom_range(0, 31));
    dia   = 4'($urandom_range(0, 15));
    dib   = 4'($urandom_range(0, 15));
  endtask

  task automatic tick();
    @(posedge clk1);
    model_step();
    #1;
  endtask

  vec_t tbl [13];

  initial begin
    int n0, n1;

    tbl[0]  = mk(1,1, 6,4'hA, 1,1, 7,4'hB,  4'h0,4'h0, 4'hA,4'hB, 0);
    tbl[1]  = mk(1,0, 6,0,    1,0, 7,0,     4'hA,4'hB, 4'hA,4'hB, 0);
    tbl[2]  = mk(1,1, 9,4'h3, 1,1, 9,4'hC,  4'h0,4'h0, 4'h3,4'hC, 1);
    tbl[3]  = mk(1,0, 9,0,    1,0, 9,0,     4'h3,4'h3, 4'h3,4'h3, 0);
    tbl[4]  = mk(1,1, 4,4'h5, 0,0, 4,0,     4'h0,4'h3, 4'h5,4'h3, 0);
    tbl[5]  = mk(1,1, 4,4'h6, 1,0, 4,0,     4'h5,4'h5, 4'h6,4'h5, 1);
    tbl[6]  = mk(1,0, 4,0,    1,0, 31,0,    4'h6,4'h0, 4'h6,4'h0, 0);
    tbl[7]  = mk(1,1, 28,4'h7, 1,0, 28,0,   4'h0,4'h0, 4'h0,4'h0, 1);
    tbl[8]  = mk(1,0, 28,0,   1,0, 27,0,    4'h7,4'h0, 4'h0,4'h0, 0);
    tbl[9]  = mk(0,1, 6,4'hF, 0,1, 7,4'hF,  4'h7,4'h0, 4'h0,4'h0, 0);
    tbl[10] = mk(1,0, 6,0,    1,0, 7,0,     4'hA,4'hB, 4'hA,4'hB, 0);
    tbl[11] = mk(1,1, 29,4'h1, 1,1, 30,4'h9, 4'h0,4'h0, 4'h0,4'h0, 0);
    tbl[12] = mk(1,0, 29,0,   1,0, 30,0,    4'h1,4'h9, 4'h0,4'h0, 0);

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk1);
    #1;
    check("reset_busy0", 32'(busy0), 32'd1);
    check("reset_busy1", 32'(busy1), 32'd1);
    check("reset_doa",   32'(doa0),  32'd0);
    check("reset_dob",   32'(dob0),  32'd0);
    check("reset_col",   32'(col0),  32'd0);

    // Start a sweep, then interrupt it at cycle 10.
    rst_n = 1'b1;
    repeat (10) @(posedge clk1);
    #1;
    check("midsweep_busy", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy0), 32'd1);
    @(posedge clk1);
    #1 rst_n = 1'b1;

    // Full sweep; random accesses in the first 20 cycles must be ignored.
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 100 && (busy0 || busy1); c++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (c < 20) drive_random();
      else        idle();
      @(posedge clk1);
      #1;
      if (c < 20) begin
        check("sweep_doa0", 32'(doa0), 32'd0);
        check("sweep_dob0", 32'(dob0), 32'd0);
        check("sweep_col0", 32'(col0), 32'd0);
        check("sweep_doa1", 32'(doa1), 32'd0);
        check("sweep_dob1", 32'(dob1), 32'd0);
        check("sweep_col1", 32'(col1), 32'd0);
      end
    end
    check("busy_cycles_depth32", 32'(n0), 32'd32);
    check("busy_cycles_depth24", 32'(n1), 32'd24);
    idle();
    model_reset();

    for (int i = 0; i < 32; i++) begin
      ena = 1'b1; wea = 1'b0; addra = 5'(i);
      enb = 1'b1; web = 1'b0; addrb = 5'(31 - i);
      tick();
      check("clear_doa0", 32'(doa0), 32'd0);
      check("clear_dob0", 32'(dob0), 32'd0);
      check("clear_doa1", 32'(doa1), 32'd0);
      check("clear_dob1", 32'(dob1), 32'd0);
    end

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      tick();
      check($sformatf("vec%0d_doa_rf", i), 32'(doa0), 32'(tbl[i].xa0));
      check($sformatf("vec%0d_dob_rf", i), 32'(dob0), 32'(tbl[i].xb0));
      check($sformatf("vec%0d_doa_wf", i), 32'(doa1), 32'(tbl[i].xa1));
      check($sformatf("vec%0d_dob_wf", i), 32'(dob1), 32'(tbl[i].xb1));
      check($sformatf("vec%0d_col_rf", i), 32'(col0), 32'(tbl[i].xc));
      check($sformatf("vec%0d_col_wf", i), 32'(col1), 32'(tbl[i].xc));
    end

`ifdef DPRAM_TDP_PARITY_EN
    idle();
    ena = 1'b1; wea = 1'b1; addra = 5'd2; dia = 4'h5;
    tick();
    wea = 1'b0;
    tick();
    check("parity_clean", 32'(pea0), 32'd0);
    u_main.mem[2][4] = ~u_main.mem[2][4];
    tick();
    check("parity_err_a", 32'(pea0), 32'd1);
    check("parity_doa",   32'(doa0), 32'h5);
    u_main.mem[2][4] = ~u_main.mem[2][4];
    idle();
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      drive_random();
      tick();
      check("rand_doa_rf", 32'(doa0), 32'(qa0));
      check("rand_dob_rf", 32'(dob0), 32'(qb0));
      check("rand_col_rf", 32'(col0), 32'(qc));
      check("rand_doa_wf", 32'(doa1), 32'(qa1));
      check("rand_dob_wf", 32'(dob1), 32'(qb1));
      check("rand_col_wf", 32'(col1), 32'(qc));
    end
    check("ready_busy0", 32'(busy0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dpram_tdp.md
Name: dpram_tdp

Overview:
- Parametrised single-clock true dual-port RAM; successor to the fixed 4-bit x 32-word dual-port RAM.
- Adds the following over that design:
  - generic width and depth;
  - per-port enables;
  - selectable same-port read-during-write mode;
  - deterministic write-write arbitration;
  - a collision flag;
  - a post-reset clear sweep with a busy indicator.
- Storage primitive for buffers and register files in the datapath.

Parameters:
- DATA_W, 4: word width in bits.
- ADDR_W, 5: address width.
- DEPTH, 32: number of words; must satisfy DEPTH <= 2**ADDR_W.
- RDW_MODE, 0: same-port read-during-write. 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk1  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_busy  out  1  high while clear sweep runs; port operations ignored.
- ena  in  1  port A enable.
- wea  in  1  port A write (qualified by ena).
- addra  in  ADDR_W  port A address.
- dia  in  DATA_W  port A write data.
- doa  out  DATA_W  port A read data.
- enb  in  1  port B enable.
- web  in  1  port B write (qualified by enb).
- addrb  in  ADDR_W  port B address.
- dib  in  DATA_W  port B write data.
- dob  out  DATA_W  port B read data.
- collision  out  1  same-address access with at least one write, seen on the previous cycle.

Behaviour:
- Reset (rst_n low, async):
  - doa, dob and collision go to 0.
  - init_busy goes to 1.
  - FSM enters CLEAR; clear counter goes to 0.
  - Memory contents are not reset asynchronously.
- FSM states are CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt.
  - On the cycle that writes cnt == DEPTH-1, the next state is READY. Clear takes exactly DEPTH cycles after rst_n rises.
  - READY: init_busy = 0. Stays in READY until the next reset.
- Reset asserted mid-sweep restarts the sweep from address 0.
- During CLEAR, ena and enb are ignored: no writes, doa/dob hold 0, collision held 0.
- Read latency is 1 cycle. When en is high, do updates on the edge after the address is presented. When en is low, do holds its last value.
- Same-port write behaviour:
  - RDW_MODE=0: do returns the pre-write contents.
  - RDW_MODE=1: do returns the write data.
- Cross-port, same address:
  - Read on one port while the other port writes: the reader gets the old data, independent of RDW_MODE.
  - Both ports write: port A wins; port B's write is dropped.
- collision is registered, so it is aligned with doa/dob of the offending access. It is set for one cycle when all of the following hold: ena && enb, addra == addrb, (wea || web).
- Addresses >= DEPTH:
  - writes are ignored;
  - reads return 0;
  - no collision is flagged unless both addresses are equal.
- All internal arithmetic is unsigned. The clear counter is ADDR_W+1 bits wide so that DEPTH == 2**ADDR_W terminates without wrap.

Optional Feature:
- Macro: DPRAM_TDP_PARITY_EN.
- When defined:
  - each word stores DATA_W+1 bits, the extra bit being even parity of the data;
  - outputs par_err_a and par_err_b (1 bit each, reset 0) are added;
  - each flag is asserted with doa/dob when the stored parity mismatches the stored data;
  - the clear sweep writes parity 0.
- When undefined: storage is DATA_W bits and the par_err ports do not exist.

Decomposition:
- Package dpram_pkg holds:
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1;
  - the clr_state_t enum {CLEAR, READY};
  - function parity(data).
- One sub-module, dpram_clear_fsm. It owns the state, the counter and init_busy, and outputs clr_we and clr_addr to the array.

Test Plan:
- Release rst_n, DEPTH=32 -> init_busy high for exactly 32 cycles; afterwards, reading addr 0..31 returns 0.
- Port A writes 0xA to addr 6 while port B writes 0xB to addr 7; next cycle read both -> doa=0xA, dob=0xB, collision=0.
- Both ports write addr 9 (A=0x3, B=0xC) -> collision=1 one cycle later; a subsequent read of addr 9 returns 0x3.
- Addr 4 holds 0x5; port A writes 0x6 to addr 4 while port B reads addr 4 -> dob=0x5, collision=1.
  - With RDW_MODE=1, port A's own read of addr 4 gives doa=0x6.
  - With RDW_MODE=0, it gives doa=0x5.
- Assert rst_n low at cycle 10 of the clear sweep, release -> init_busy is high for a full 32 cycles again; accesses during the sweep are ignored.
- With DPRAM_TDP_PARITY_EN defined, force-flip a stored parity bit at addr 2 and read it -> par_err_a=1 with doa.
